// File: rtl/alu_pkg.sv
// Shared types and helpers for the PID datapath ALU: FSM state, mode-bit
// positions and the signed clamp used by both the add/sub and multiply paths.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int unsigned MB_SAT      = 0;
  localparam int unsigned MB_MULT4    = 1;
  localparam int unsigned MB_MULT2    = 2;
  localparam int unsigned MB_SUB      = 3;
  localparam int unsigned MB_MULTIPLY = 4;
  localparam int unsigned MODE_W      = 5;

  typedef struct packed {
    logic signed [63:0] value;
    logic               ovf;
  } sat_t;

  // Clamp a sign-extended value to a signed field of 'width' bits.
  function automatic sat_t sat_signed(input logic signed [63:0] value,
                                      input int unsigned         width);
    logic signed [63:0] w_max;
    logic signed [63:0] w_min;
    sat_t               w_res;
    w_max       = (64'sd1 <<< (width - 1)) - 64'sd1;
    w_min       = -(64'sd1 <<< (width - 1));
    w_res.value = value;
    w_res.ovf   = 1'b0;
    if (value > w_max) begin
      w_res.value = w_max;
      w_res.ovf   = 1'b1;
    end else if (value < w_min) begin
      w_res.value = w_min;
      w_res.ovf   = 1'b1;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle between the operand-select muxes, the ALU and the
// accumulator register.
interface alu_pipe_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic [W-1:0] src1;
  logic [W-1:0] src0;
  logic         multiply;
  logic         sub;
  logic         mult2;
  logic         mult4;
  logic         saturate;
  logic         busy;
  logic         done;
  logic [W-1:0] dst;
  logic         ovf;

  modport master (
    output start, src1, src0, multiply, sub, mult2, mult4, saturate,
    input  busy, done, dst, ovf
  );

  modport slave (
    input  start, src1, src0, multiply, sub, mult2, mult4, saturate,
    output busy, done, dst, ovf
  );
endinterface

// File: rtl/alu_seq_mult.sv
// Iterative sign-magnitude shift-add multiplier: one magnitude bit per clock,
// final signed product presented combinationally in the finishing cycle.
module alu_seq_mult
  import alu_pkg::*;
#(
  parameter int unsigned N = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [N-1:0]         i_a,
  input  logic [N-1:0]         i_b,
  output logic                 o_busy,
  output logic                 o_fin,
  output logic signed [2*N:0]  o_prod
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*N-1:0]     r_mcand;
  logic [N-1:0]       r_mplier;
  logic [2*N-1:0]     r_acc;
  logic               r_sign;
  logic [CW-1:0]      r_count;
  logic               w_last;
  logic [N-1:0]       w_abs_a;
  logic [N-1:0]       w_abs_b;
  logic signed [2*N:0] w_mag;

  assign w_last = (r_count == CW'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_load) w_state_nxt = MUL;
      MUL:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == MUL);
    o_fin  = (r_state == MUL) && w_last;
  end

  // The most negative operand negates to 2^(N-1), which still fits N bits.
  always_comb begin
    w_abs_a = i_a[N-1] ? ((~i_a) + N'(1)) : i_a;
    w_abs_b = i_b[N-1] ? ((~i_b) + N'(1)) : i_b;
    w_mag   = {1'b0, r_acc};
    o_prod  = r_sign ? -w_mag : w_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_sign   <= 1'b0;
      r_count  <= '0;
    end else if (r_state == IDLE && i_load) begin
      r_mcand  <= {{N{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_acc    <= '0;
      r_sign   <= i_a[N-1] ^ i_b[N-1];
      r_count  <= '0;
    end else if (r_state == MUL && !w_last) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// PID datapath ALU: single-cycle scaled add/sub with optional clamp, and a
// multi-cycle fractional multiply; result and overflow flag are registered.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned SAT_W    = 12,
  parameter int unsigned MUL_FRAC = 12,
  parameter int unsigned MSAT_W   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  logic [MODE_W-1:0]   w_mode;
  logic [W-1:0]        w_scaled0;
  logic [W-1:0]        w_addend;
  logic [W-1:0]        w_sum;
  sat_t                w_add_sat;
  sat_t                w_mul_sat;
  logic signed [2*W-2:0] w_prod;
  logic signed [2*W-2:0] w_shr;
  logic                w_busy;
  logic                w_fin;
  logic                w_accept;
  logic                w_add_go;
  logic                w_mul_go;
  logic                w_unused;

  logic [W-1:0]        r_dst;
  logic                r_done;
  logic                r_ovf;

  assign w_mode = {bus.multiply, bus.sub, bus.mult2, bus.mult4, bus.saturate};

  assign w_accept = bus.start && !w_busy;
  assign w_add_go = w_accept && !w_mode[MB_MULTIPLY];
  assign w_mul_go = w_accept &&  w_mode[MB_MULTIPLY];

  always_comb begin
    w_scaled0 = bus.src0;
    if (w_mode[MB_MULT2])      w_scaled0 = bus.src0 << 1;
    else if (w_mode[MB_MULT4]) w_scaled0 = bus.src0 << 2;

    w_addend  = w_mode[MB_SUB] ? ~w_scaled0 : w_scaled0;
    w_sum     = bus.src1 + w_addend + W'(w_mode[MB_SUB]);

    w_add_sat = sat_signed(64'(signed'(w_sum)), SAT_W);
    if (!w_mode[MB_SAT]) begin
      w_add_sat.value = 64'(signed'(w_sum));
      w_add_sat.ovf   = 1'b0;
    end

    w_shr     = w_prod >>> MUL_FRAC;
    w_mul_sat = sat_signed(64'(w_shr), MSAT_W);
  end

  alu_seq_mult #(
    .N (W - 1)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_mul_go),
    .i_a    (bus.src1[W-2:0]),
    .i_b    (w_scaled0[W-2:0]),
    .o_busy (w_busy),
    .o_fin  (w_fin),
    .o_prod (w_prod)
  );

  // Start is gated by busy, so an add can never collide with a multiply finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dst  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_add_go) begin
        r_dst  <= w_add_sat.value[W-1:0];
        r_ovf  <= w_add_sat.ovf;
        r_done <= 1'b1;
      end else if (w_fin) begin
        r_dst  <= w_mul_sat.value[W-1:0];
        r_ovf  <= w_mul_sat.ovf;
        r_done <= 1'b1;
      end
    end
  end

  assign w_unused = &{1'b0, w_add_sat.value[63:W], w_mul_sat.value[63:W]};

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.dst  = r_dst;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: table of hand-computed vectors plus sequences
// for ignored starts, back-to-back requests and reset during a multiply.
module tb_alu_pipe;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_pipe_if #(.W(W)) bus ();

  alu_pipe #(
    .W        (W),
    .SAT_W    (12),
    .MUL_FRAC (12),
    .MSAT_W   (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] src1;
    logic [15:0] src0;
    logic        multiply;
    logic        sub;
    logic        mult2;
    logic        mult4;
    logic        saturate;
    logic [15:0] exp_dst;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string n, input logic [15:0] s1, input logic [15:0] s0,
                                  input logic m, input logic sb, input logic m2, input logic m4,
                                  input logic sat, input logic [15:0] ed, input logic eo);
    vec_t v;
    v.name = n; v.src1 = s1; v.src0 = s0; v.multiply = m; v.sub = sb;
    v.mult2 = m2; v.mult4 = m4; v.saturate = sat; v.exp_dst = ed; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [15:0] s1, input logic [15:0] s0, input logic m,
                       input logic sb, input logic m2, input logic m4, input logic sat);
    bus.src1 = s1; bus.src0 = s0; bus.multiply = m; bus.sub = sb;
    bus.mult2 = m2; bus.mult4 = m4; bus.saturate = sat;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int nbusy;
    bit got;
    drive(v.src1, v.src0, v.multiply, v.sub, v.mult2, v.mult4, v.saturate);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive(~v.src1, v.src0 ^ 16'h5A5A, ~v.multiply, ~v.sub, ~v.mult2, ~v.mult4, ~v.saturate);
    lat = 0; nbusy = 0; got = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      if (bus.done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
    end
    n_vec++;
    chk({v.name, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({v.name, " latency"},    32'(lat),      v.multiply ? 32'(W) : 32'd0);
      chk({v.name, " busy_cyc"},   32'(nbusy),    v.multiply ? 32'(W) : 32'd0);
      chk({v.name, " busy_at_done"}, 32'(bus.busy), 32'd0);
      chk({v.name, " dst"},        32'(bus.dst),  32'(v.exp_dst));
      chk({v.name, " ovf"},        32'(bus.ovf),  32'(v.exp_ovf));
      @(posedge clk); #1;
      chk({v.name, " done_pulse"}, 32'(bus.done), 32'd0);
      chk({v.name, " dst_hold"},   32'(bus.dst),  32'(v.exp_dst));
    end
  endtask

  initial begin
    int ndone;
    int done_at;

    //        name             src1      src0     mul  sub  m2   m4   sat   dst      ovf
    add_vec("add_mult4",      16'h0100, 16'h0050, 0,   0,   0,   1,   0,   16'h0240, 0);
    add_vec("sub_sat",        16'hF900, 16'h0200, 0,   1,   0,   0,   1,   16'hF800, 1);
    add_vec("sub_nosat",      16'hF900, 16'h0200, 0,   1,   0,   0,   0,   16'hF700, 0);
    add_vec("add_plain",      16'h1234, 16'h0001, 0,   0,   0,   0,   0,   16'h1235, 0);
    add_vec("add_wrap",       16'h7FFF, 16'h0001, 0,   0,   0,   0,   0,   16'h8000, 0);
    add_vec("add_wrap_sat",   16'h7FFF, 16'h0001, 0,   0,   0,   0,   1,   16'hF800, 1);
    add_vec("add_pos_sat",    16'h0700, 16'h0200, 0,   0,   1,   0,   1,   16'h07FF, 1);
    add_vec("add_max_edge",   16'h07FF, 16'h0000, 0,   0,   0,   0,   1,   16'h07FF, 0);
    add_vec("sub_min_edge",   16'h0000, 16'h0800, 0,   1,   0,   0,   1,   16'hF800, 0);
    add_vec("sub_min_m1",     16'h0000, 16'h0801, 0,   1,   0,   0,   1,   16'hF800, 1);
    add_vec("m2_priority",    16'h0000, 16'h0003, 0,   0,   1,   1,   0,   16'h0006, 0);
    add_vec("sub_mult2",      16'h0010, 16'h0004, 0,   1,   1,   0,   0,   16'h0008, 0);
    add_vec("mul_basic",      16'h1000, 16'h0800, 1,   0,   0,   0,   0,   16'h0800, 0);
    add_vec("mul_pos_sat",    16'hC000, 16'hC000, 1,   0,   0,   0,   0,   16'h3FFF, 1);
    add_vec("mul_neg_sat",    16'h3FFF, 16'hC000, 1,   0,   0,   0,   0,   16'hC000, 1);
    add_vec("mul_neg",        16'hFFFF, 16'h1000, 1,   0,   0,   0,   0,   16'hFFFF, 0);
    add_vec("mul_trunc",      16'h0003, 16'h0001, 1,   0,   0,   0,   0,   16'h0000, 0);
    add_vec("mul_neg_floor",  16'h7FFD, 16'h0001, 1,   0,   0,   0,   0,   16'hFFFF, 0);
    add_vec("mul_ign_flags",  16'h2000, 16'h2000, 1,   1,   0,   0,   0,   16'h3FFF, 1);
    add_vec("mul_msb_ign",    16'h9000, 16'h0800, 1,   0,   0,   0,   0,   16'h0800, 0);
    add_vec("mul_mult2",      16'h1000, 16'h0400, 1,   0,   1,   0,   0,   16'h0800, 0);
    add_vec("mul_m4_neg",     16'h0010, 16'h1000, 1,   0,   0,   1,   0,   16'hFFC0, 0);
    add_vec("mul_max_edge",   16'h3FFF, 16'h1000, 1,   0,   0,   0,   0,   16'h3FFF, 0);
    add_vec("mul_min_edge",   16'h4000, 16'h1000, 1,   0,   0,   0,   0,   16'hC000, 0);

    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive(16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst dst",  32'(bus.dst),  32'd0);
    chk("rst ovf",  32'(bus.ovf),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Starts during a multiply are dropped; an add in the done cycle is taken.
    drive(16'h1000, 16'h0800, 1, 0, 0, 0, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; done_at = 0;
    for (int i = 1; i <= int'(W); i++) begin
      if (i == 3 || i == 8) begin
        bus.start = 1'b1;
        drive(16'h0111, 16'h0222, 0, 0, 0, 0, 0);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        done_at = i;
      end
    end
    n_vec++;
    chk("ign_start ndone",   32'(ndone),   32'd1);
    chk("ign_start done_at", 32'(done_at), 32'(W));
    chk("ign_start dst",     32'(bus.dst), 32'h0800);
    chk("ign_start ovf",     32'(bus.ovf), 32'd0);

    drive(16'h0001, 16'h0002, 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    chk("b2b_a done", 32'(bus.done), 32'd1);
    chk("b2b_a dst",  32'(bus.dst),  32'h0003);
    drive(16'h0010, 16'h0020, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_vec++;
    chk("b2b_b done", 32'(bus.done), 32'd1);
    chk("b2b_b dst",  32'(bus.dst),  32'h0030);
    @(posedge clk); #1;
    chk("b2b idle done", 32'(bus.done), 32'd0);

    // Reset in the middle of a multiply aborts it without a done pulse.
    drive(16'h1000, 16'h0800, 1, 0, 0, 0, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("mid_rst busy", 32'(bus.busy), 32'd0);
    chk("mid_rst done", 32'(bus.done), 32'd0);
    chk("mid_rst dst",  32'(bus.dst),  32'd0);
    chk("mid_rst ovf",  32'(bus.ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    chk("post_rst quiet", 32'(ndone), 32'd0);

    begin
      vec_t v;
      v.name = "mul_after_rst"; v.src1 = 16'h0800; v.src0 = 16'h0800; v.multiply = 1'b1;
      v.sub = 1'b0; v.mult2 = 1'b0; v.mult4 = 1'b0; v.saturate = 1'b0;
      v.exp_dst = 16'h0400; v.exp_ovf = 1'b0;
      run_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
